bcd_stopwatch: RTL and testbench
================================

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter TICK_DIV, default 10000: Clk cycles per count increment (≥2).
REQ-002 Parameter DEB_CYC, default 20000: cycles a button level must be stable to be accepted (≥1).
REQ-003 Clk  input  1  single system clock; all state on rising edge.
REQ-004 Aclr  input  1  reset, asynchronous, active-low.
REQ-005 StartStop  input  1  raw push-button, active-high, asynchronous to Clk.
REQ-006 Clr  input  1  raw push-button, active-high, asynchronous to Clk.
REQ-007 A  output  4  BCD thousands digit, leftmost display position.
REQ-008 B  output  4  BCD hundreds digit.
REQ-009 C  output  4  BCD tens digit.
REQ-010 D  output  4  BCD units digit, rightmost position.
REQ-011 Run  output  1  high while state is RUN.
REQ-012 Ovf  output  1  one-cycle pulse on 9999->0000 wrap.

Function
REQ-013 Each button passes a 2-FF synchronizer, then a debouncer: accepted level changes only after the synchronized level differs from it for DEB_CYC consecutive cycles.
REQ-014 A press event is a single-cycle pulse on the accepted level's 0->1 transition; releases generate no event.
REQ-015 The FSM shall act on a press event on the next clock edge; the total pin-to-state latency shall be DEB_CYC+3 to DEB_CYC+4 cycles.
REQ-016 FSM states: IDLE (count 0000, stopped), RUN, PAUSE.
REQ-017 IDLE: StartStop press -> RUN; Clr press -> stay IDLE.
REQ-018 RUN: StartStop press -> PAUSE; Clr press ignored.
REQ-019 PAUSE: StartStop press -> RUN; Clr press -> IDLE, digits and prescaler cleared.
REQ-020 Simultaneous StartStop and Clr events: in IDLE/PAUSE Clr wins and StartStop is dropped; in RUN StartStop wins and Clr is dropped.
REQ-021 The prescaler counts 0..TICK_DIV-1 only in RUN, holds its value in PAUSE, and is zero in IDLE; a tick is issued in the cycle it equals TICK_DIV-1, and it returns to 0.
REQ-022 The prescaler is not reset on RUN<->PAUSE, so accumulated partial periods are preserved.
REQ-023 On a tick, D increments; a digit at 9 wraps to 0 and carries into the next digit to its left; digits update registered, same edge.
REQ-024 At 9999 a tick yields 0000, Ovf=1 for that cycle only, and the state remains RUN.
REQ-025 Digits never hold values 10-15; outputs are registers, glitch-free, directly usable by the display multiplexer.
REQ-026 A tick coinciding with a StartStop press in RUN is counted; the transition to PAUSE happens on the same edge.

Reset
REQ-027 Aclr low asynchronously forces: state IDLE, A=B=C=D=0, Run=0, Ovf=0, prescaler 0, synchronizers and accepted levels 0, debounce counters 0.
REQ-028 Reset deassertion is synchronized externally; no press event is generated by reset release even if a button is held (accepted level starts 0 and requires DEB_CYC stability).
REQ-029 Reset asserted mid-RUN discards the count; there is no retention.

Structure
REQ-030 Package bcd_stopwatch_pkg holds: state enum (IDLE, RUN, PAUSE), 4-bit BCD digit type, constant DIGIT_MAX=9.
REQ-031 Sub-module btn_conditioner (synchronizer + debouncer + rising-edge pulse, parameter DEB_CYC), instantiated once per button.
REQ-032 Prescaler, FSM and 4-digit BCD chain reside in bcd_stopwatch; target 150-300 RTL lines total.

Verification (bench: TICK_DIV=4, DEB_CYC=2)
REQ-033 Reset, then StartStop pulse 10 cycles -> Run=1 within 6 cycles; after 4*12 further cycles, ABCD=0012.
REQ-034 Running, StartStop press -> Run=0, digits frozen 100 cycles; press again -> counting resumes, with the first tick no later than 4 cycles after resume.
REQ-035 Preload by running to 9998, two ticks -> 9999 then 0000, Ovf high exactly one cycle, Run stays 1.
REQ-036 StartStop glitch of 1 cycle (shorter than DEB_CYC) -> no state change; Clr in RUN -> ignored, count continues.
REQ-037 PAUSE at 0347, StartStop and Clr raised on the same cycle -> IDLE, ABCD=0000, Run=0.
REQ-038 Aclr pulsed low mid-RUN at 0123 -> immediate ABCD=0000, Run=0; while StartStop is held through release, no start occurs until it is released and pressed again.

Source files
------------

// File: rtl/bcd_stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch_pkg
//   Shared types and constants for the 4-digit BCD stopwatch.
//   - state_t    : control FSM states (IDLE / RUN / PAUSE)
//   - bcd_t      : one BCD digit (0..9, never 10..15)
//   - DIGIT_MAX  : largest legal BCD digit value
//   - bcd_inc()  : one stage of the ripple-carry BCD incrementer
// -----------------------------------------------------------------------------
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX  = 4'd9;
    localparam int   NUM_DIGITS = 4;

    typedef struct packed {
        logic carry;
        bcd_t digit;
    } bcd_step_t;

    // Adds carry-in to one digit; wraps 9 -> 0 and propagates the carry.
    function automatic bcd_step_t bcd_inc(input bcd_t d, input logic cin);
        bcd_step_t r;
        r.carry = cin && (d == DIGIT_MAX);
        if (!cin)
            r.digit = d;
        else if (d == DIGIT_MAX)
            r.digit = '0;
        else
            r.digit = d + 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Cleans one raw push-button: 2-FF synchronizer, level debouncer and
//   single-cycle press pulse on the accepted 0->1 transition.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     btn    in   raw active-high button, asynchronous to clk
//     press  out  one-cycle registered pulse per accepted press
//   A button already held when reset is released never produces a press:
//   presses are only armed once a genuine low level has been seen for
//   DEB_CYC consecutive cycles.
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEB_CYC = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [1:0]       fill;       // tracks when sync_q2 holds a real sample
    logic             level;      // accepted (debounced) level
    logic [CNT_W-1:0] deb_cnt;
    logic             armed;
    logic [CNT_W-1:0] arm_cnt;
    logic             sync_valid;

    assign sync_valid = fill[1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, as real hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            fill    <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            fill    <= {fill[0], 1'b1};
        end
    end

    // Accepted level flips only after the synchronized input has disagreed
    // with it for DEB_CYC consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 1'b0;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q2 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                level   <= sync_q2;
                deb_cnt <= '0;
                press   <= sync_q2 & armed;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Arming: a real low level must be observed before presses count, so a
    // button held through reset release is ignored until released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            arm_cnt <= '0;
        end else if (!armed) begin
            if (!sync_valid || sync_q2)
                arm_cnt <= '0;
            else if (arm_cnt == CNT_LAST)
                armed <= 1'b1;
            else
                arm_cnt <= arm_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch
//   Four-digit BCD stopwatch with start/stop and clear buttons.
//   Ports:
//     Clk        in   system clock, all state on rising edge
//     Aclr       in   asynchronous active-low reset
//     StartStop  in   raw start/stop push-button (active-high)
//     Clr        in   raw clear push-button (active-high)
//     A,B,C,D    out  BCD digits, thousands (A) .. units (D), registered
//     Run        out  high while in RUN
//     Ovf        out  one-cycle pulse when the count wraps 9999 -> 0000
//   Parameters:
//     TICK_DIV   clock cycles per count increment (>= 2)
//     DEB_CYC    debounce stability window in cycles (>= 1)
// -----------------------------------------------------------------------------
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 10000,
    parameter int DEB_CYC  = 20000
) (
    input  logic       Clk,
    input  logic       Aclr,
    input  logic       StartStop,
    input  logic       Clr,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic       Run,
    output logic       Ovf
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t                  state;
    state_t                  state_next;
    logic                    ss_press;
    logic                    clr_press;
    logic [PRE_W-1:0]        presc;
    logic                    tick;
    bcd_t [NUM_DIGITS-1:0]   digits;       // [0] = units
    bcd_t [NUM_DIGITS-1:0]   digits_next;
    logic                    wrap;
    logic                    carry;
    bcd_step_t               step;

    btn_conditioner #(.DEB_CYC(DEB_CYC)) u_ss_btn (
        .clk   (Clk),
        .rst_n (Aclr),
        .btn   (StartStop),
        .press (ss_press)
    );

    btn_conditioner #(.DEB_CYC(DEB_CYC)) u_clr_btn (
        .clk   (Clk),
        .rst_n (Aclr),
        .btn   (Clr),
        .press (clr_press)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Clear beats start/stop when stopped; start/stop beats clear in RUN,
    // where clear has no effect anyway.
    // NOTE: the default assignment at the top of a combinational block keeps
    // every path driven, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (clr_press)
                    state_next = IDLE;
                else if (ss_press)
                    state_next = RUN;
            end
            RUN: begin
                if (ss_press)
                    state_next = PAUSE;
            end
            PAUSE: begin
                if (clr_press)
                    state_next = IDLE;
                else if (ss_press)
                    state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign Run  = (state == RUN);
    assign tick = (state == RUN) && (presc == PRE_LAST);

    // ---------------- BCD ripple incrementer ----------------
    always_comb begin
        digits_next = digits;
        carry       = tick;
        step        = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            step           = bcd_inc(digits[i], carry);
            digits_next[i] = step.digit;
            carry          = step.carry;
        end
        wrap = carry;
    end

    // ---------------- prescaler, digits, overflow ----------------
    // The prescaler advances on every RUN edge, including the edge that
    // leaves RUN, so a tick coinciding with a stop press is still counted
    // and partial periods survive PAUSE.
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            presc  <= '0;
            digits <= '0;
            Ovf    <= 1'b0;
        end else if (state_next == IDLE) begin
            presc  <= '0;
            digits <= '0;
            Ovf    <= 1'b0;
        end else begin
            if (state == RUN)
                presc <= tick ? '0 : presc + 1'b1;
            digits <= digits_next;
            Ovf    <= wrap;
        end
    end

    assign A = digits[3];
    assign B = digits[2];
    assign C = digits[1];
    assign D = digits[0];

endmodule

// File: tb/tb_bcd_stopwatch.sv
// -----------------------------------------------------------------------------
// tb_bcd_stopwatch
//   Self-checking bench for bcd_stopwatch with TICK_DIV=4, DEB_CYC=2.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. A button asserted just after falling edge N is acted on by the FSM
//   at rising edge N+5 (2 sync + 2 debounce + 1 FSM).
// -----------------------------------------------------------------------------
module tb_bcd_stopwatch;

    localparam int TICK_DIV = 4;
    localparam int DEB_CYC  = 2;

    logic        Clk = 1'b0;
    logic        Aclr;
    logic        StartStop;
    logic        Clr;
    logic [3:0]  A;
    logic [3:0]  B;
    logic [3:0]  C;
    logic [3:0]  D;
    logic        Run;
    logic        Ovf;
    logic [15:0] abcd;

    int n_cmp      = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int ovf_pulses = 0;

    typedef struct {
        logic        ss;
        logic        cl;
        logic        exp_run;
        logic [15:0] exp_abcd;
        string       name;
    } vec_t;

    vec_t vecs [12];

    bcd_stopwatch #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
        .Clk       (Clk),
        .Aclr      (Aclr),
        .StartStop (StartStop),
        .Clr       (Clr),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .Run       (Run),
        .Ovf       (Ovf)
    );

    assign abcd = {A, B, C, D};

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) if (Ovf === 1'b1) ovf_pulses <= ovf_pulses + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic ss, input logic cl,
                           input logic r, input logic [15:0] d, input string n);
        vecs[i].ss       = ss;
        vecs[i].cl       = cl;
        vecs[i].exp_run  = r;
        vecs[i].exp_abcd = d;
        vecs[i].name     = n;
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic do_reset();
        Aclr = 1'b0;
        repeat (2) @(negedge Clk);
        Aclr = 1'b1;
        repeat (6) @(negedge Clk);
    endtask

    // Drives buttons for 'hold' cycles, returns cycles until Run == want
    // (-1 if not seen within hold + 8 cycles).
    task automatic press_watch(input logic ss, input logic cl, input int hold,
                               input logic want, output int lat);
        int c0;
        c0  = cyc;
        lat = -1;
        StartStop = ss;
        Clr       = cl;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            if (lat < 0 && Run === want) lat = cyc - c0;
        end
        StartStop = 1'b0;
        Clr       = 1'b0;
        for (int i = 0; i < 8 && lat < 0; i++) begin
            @(negedge Clk);
            if (Run === want) lat = cyc - c0;
        end
    endtask

    task automatic wait_digits(input logic [15:0] target, input int budget, output bit found);
        int n;
        n = 0;
        while (abcd !== target && n < budget) begin
            @(negedge Clk);
            n++;
        end
        found = (abcd === target);
    endtask

    initial begin : main
        int  lat;
        int  c0;
        int  t_run;
        int  v;
        int  p0;
        bit  found;
        bit  moved;

        // Table from a fresh reset; each row: press 4 cycles, idle 6, sample.
        // Prescaler phase is carried from row to row (hand-derived counts).
        set_vec(0,  1'b0, 1'b0, 1'b0, 16'h0000, "idle_none");
        set_vec(1,  1'b0, 1'b1, 1'b0, 16'h0000, "idle_clr");
        set_vec(2,  1'b1, 1'b0, 1'b1, 16'h0001, "idle_start");
        set_vec(3,  1'b0, 1'b1, 1'b1, 16'h0003, "run_clr_ignored");
        set_vec(4,  1'b1, 1'b0, 1'b0, 16'h0005, "run_pause_tick_same_edge");
        set_vec(5,  1'b1, 1'b0, 1'b1, 16'h0006, "pause_resume");
        set_vec(6,  1'b1, 1'b1, 1'b0, 16'h0007, "run_both_ss_wins");
        set_vec(7,  1'b0, 1'b1, 1'b0, 16'h0000, "pause_clr");
        set_vec(8,  1'b1, 1'b1, 1'b0, 16'h0000, "idle_both_clr_wins");
        set_vec(9,  1'b1, 1'b0, 1'b1, 16'h0001, "idle_start2");
        set_vec(10, 1'b1, 1'b0, 1'b0, 16'h0002, "run_pause2");
        set_vec(11, 1'b1, 1'b1, 1'b0, 16'h0000, "pause_both_clr_wins");

        Aclr      = 1'b0;
        StartStop = 1'b0;
        Clr       = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_abcd", abcd, 16'h0000);
        check("reset_run", Run, 1'b0);
        check("reset_ovf", Ovf, 1'b0);
        Aclr = 1'b1;
        repeat (6) @(negedge Clk);

        for (int i = 0; i < 12; i++) begin
            StartStop = vecs[i].ss;
            Clr       = vecs[i].cl;
            repeat (4) @(negedge Clk);
            StartStop = 1'b0;
            Clr       = 1'b0;
            repeat (6) @(negedge Clk);
            check({vecs[i].name, "_run"}, Run, vecs[i].exp_run);
            check({vecs[i].name, "_abcd"}, abcd, vecs[i].exp_abcd);
        end

        // Start with a 10-cycle press, then 48 cycles -> 12 ticks.
        do_reset();
        c0 = cyc;
        press_watch(1'b1, 1'b0, 10, 1'b1, lat);
        check("start_latency_5_to_6", (lat >= 5 && lat <= 6), 1'b1);
        t_run = c0 + lat;
        while (cyc < t_run + 48) @(negedge Clk);
        check("count_0012", abcd, 16'h0012);
        check("count_0012_run", Run, 1'b1);

        // Pause: tick at +4 gives 0013, stop at +5; frozen 100 cycles.
        press_watch(1'b1, 1'b0, 4, 1'b0, lat);
        check("pause_latency_5_to_6", (lat >= 5 && lat <= 6), 1'b1);
        check("pause_abcd", abcd, 16'h0013);
        moved = 1'b0;
        repeat (100) begin
            @(negedge Clk);
            if (abcd !== 16'h0013 || Run !== 1'b0) moved = 1'b1;
        end
        check("pause_frozen", moved, 1'b0);
        press_watch(1'b1, 1'b0, 4, 1'b1, lat);
        check("resume_latency_5_to_6", (lat >= 5 && lat <= 6), 1'b1);
        wait_digits(16'h0014, 4, found);
        check("resume_first_tick_by_4", found, 1'b1);

        // One-cycle StartStop glitch, then Clr in RUN: 40 cycles -> +10.
        v  = bcd2int(abcd);
        c0 = cyc;
        StartStop = 1'b1;
        @(negedge Clk);
        StartStop = 1'b0;
        repeat (6) @(negedge Clk);
        Clr = 1'b1;
        repeat (4) @(negedge Clk);
        Clr = 1'b0;
        while (cyc < c0 + 40) @(negedge Clk);
        check("glitch_clr_run", Run, 1'b1);
        check("glitch_clr_count", bcd2int(abcd), v + 10);

        // Overflow 9999 -> 0000.
        wait_digits(16'h9998, 45000, found);
        check("reach_9998", found, 1'b1);
        wait_digits(16'h9999, 5, found);
        check("reach_9999", found, 1'b1);
        check("ovf_low_at_9999", Ovf, 1'b0);
        p0 = ovf_pulses;
        wait_digits(16'h0000, 5, found);
        check("wrap_0000", found, 1'b1);
        check("ovf_high_at_wrap", Ovf, 1'b1);
        check("run_at_wrap", Run, 1'b1);
        @(negedge Clk);
        check("ovf_low_after_wrap", Ovf, 1'b0);
        repeat (6) @(negedge Clk);
        check("ovf_single_pulse", ovf_pulses - p0, 1);
        check("run_after_wrap", Run, 1'b1);

        // Pause at 0347: press as 0346 appears; tick at +4, stop at +5.
        wait_digits(16'h0346, 1500, found);
        check("reach_0346", found, 1'b1);
        press_watch(1'b1, 1'b0, 4, 1'b0, lat);
        check("pause_0347_abcd", abcd, 16'h0347);
        check("pause_0347_run", Run, 1'b0);
        StartStop = 1'b1;
        Clr       = 1'b1;
        repeat (4) @(negedge Clk);
        StartStop = 1'b0;
        Clr       = 1'b0;
        repeat (6) @(negedge Clk);
        check("both_in_pause_abcd", abcd, 16'h0000);
        check("both_in_pause_run", Run, 1'b0);

        // Async reset mid-RUN at 0123 with StartStop held through release.
        press_watch(1'b1, 1'b0, 4, 1'b1, lat);
        wait_digits(16'h0123, 600, found);
        check("reach_0123", found, 1'b1);
        Aclr      = 1'b0;
        StartStop = 1'b1;
        #1;
        check("async_reset_abcd", abcd, 16'h0000);
        check("async_reset_run", Run, 1'b0);
        repeat (2) @(negedge Clk);
        Aclr  = 1'b1;
        moved = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            if (Run !== 1'b0) moved = 1'b1;
        end
        check("held_through_reset_no_start", moved, 1'b0);
        StartStop = 1'b0;
        repeat (8) @(negedge Clk);
        press_watch(1'b1, 1'b0, 4, 1'b1, lat);
        check("restart_after_release", (lat >= 5 && lat <= 6), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
